tpx3_packet_merger: RTL and testbench
=====================================

# tpx3_packet_merger

Reassembles 48-bit Timepix3 packets from the 25-bit half-packet words produced by the per-link receiver FIFO. Each receiver word carries 24 data bits plus a flag in bit 24: 1 marks the first half (bytes 0..2), 0 marks the second half (bytes 3..5). The block sits directly downstream of the receiver FIFO and presents whole packets on a valid/ready stream to the readout arbiter. It also detects and counts framing violations.

## Interface
- CNT_W, 8: width of the saturating error counters.
- PKT_CNT_W, 16: width of the wrapping packet counter.
- WCLK  in  1  clock; the receiver FIFO read side and the output stream run on it.
- RESET  in  1  synchronous, active-high reset.
- enable  in  1  1 = consume input; 0 = stop reading and discard any held first half.
- err_reset  in  1  synchronous clear of the error counters only.
- fifo_data  in  25  receiver FIFO output, first-word-fall-through; valid whenever fifo_empty=0.
- fifo_empty  in  1  receiver FIFO empty.
- fifo_read  out  1  pops the current FIFO word.
- out_data  out  48  merged packet, {first[23:0], second[23:0]}.
- out_valid  out  1  out_data holds a packet.
- out_ready  in  1  downstream accepts the packet when out_valid=1.
- pkt_cnt  out  PKT_CNT_W  packets emitted; wraps.
- orphan_cnt  out  CNT_W  second halves received with no first half held; saturating.
- dup_first_cnt  out  CNT_W  first halves that overwrote a held first half; saturating.

## Operation
- FSM states:
  - EMPTY: no half held.
  - HALF: first half held in hold_reg.
- Word consumption: a word is consumed when fifo_read=1.
- fifo_read = enable & !fifo_empty & (!out_valid | out_ready). fifo_read is combinational.
- EMPTY, flag=1: store bits [23:0] in hold_reg, go to HALF.
- EMPTY, flag=0: drop the word, orphan_cnt+1, stay in EMPTY.
- HALF, flag=0: load out_data={hold_reg, word[23:0]}, set out_valid=1, pkt_cnt+1, go to EMPTY.
- HALF, flag=1: overwrite hold_reg, dup_first_cnt+1, stay in HALF.
- Output handshake: when out_valid & out_ready and no new packet completes in that cycle, out_valid goes to 0.
- Simultaneous accept and completion (out_ready=1 while a second half is consumed): out_data takes the new packet and out_valid stays 1.
- enable=0: no reads; the FSM goes to EMPTY next cycle, dropping any held half without counting it. A pending out_valid is unaffected.
- Saturating counters hold at all-ones. pkt_cnt wraps to 0.

## Timing
- Reset values: state=EMPTY, hold_reg=0, out_data=0, out_valid=0, pkt_cnt=0, orphan_cnt=0, dup_first_cnt=0. fifo_read=0 because enable is gated by reset.
- RESET mid-packet discards the held half and any pending out_valid.
- err_reset clears orphan_cnt and dup_first_cnt next cycle. pkt_cnt and the FSM are untouched.
- Latency: second half consumed in cycle N gives out_valid=1 in cycle N+1. Counters update in cycle N+1.
- Throughput: one word per cycle, one packet per two cycles with out_ready held at 1.
- Backpressure: out_valid=1 & out_ready=0 forces fifo_read=0. out_data stays stable until accepted.
- fifo_empty=1 in state HALF: the held half is kept indefinitely. There is no timeout.

## Configuration
- TPX3_MERGE_ERR_CNT_EN
  - Defined: orphan_cnt and dup_first_cnt are implemented as specified.
  - Undefined: both ports are tied to 0 and their counter logic is removed. Drop and overwrite behaviour is unchanged.

## Structure
- Package tpx3_rx_pkg holds:
  - constants WORD_W=25, HALF_W=24, PKT_W=48, FLAG_BIT=24;
  - the FSM state typedef (EMPTY, HALF).
- Sub-module sat_counter: CNT_W-wide saturating counter with synchronous clear and increment enable. It is instantiated twice.

## Test plan
- Words 0x1ABCDEF, 0x0123456 back-to-back, out_ready=1 -> one packet 0xABCDEF123456, out_valid high 1 cycle, pkt_cnt=1, error counters 0.
- Words 0x0000011 (orphan), then 0x1AAAAAA, 0x0BBBBBB -> orphan_cnt=1, single packet 0xAAAAAABBBBBB.
- Words 0x1111111, 0x1222222, 0x0333333 -> dup_first_cnt=1, packet 0x222222333333.
- Two full packets queued, out_ready=0 for 5 cycles then 1 -> fifo_read=0 while blocked, first packet stable, then both packets delivered in order with no loss.
- RESET asserted in state HALF, then 0x0444444 -> no packet, orphan_cnt=1. 300 orphans -> orphan_cnt=0xFF, then err_reset -> 0.
- Macro undefined, orphan stimulus -> orphan_cnt stays 0, packet stream identical to the macro-defined run.

Source files
------------

// File: rtl/tpx3_rx_pkg.sv
// tpx3_rx_pkg: shared widths and FSM state type for the Timepix3 receive path
package tpx3_rx_pkg;
    localparam int WORD_W   = 25;
    localparam int HALF_W   = 24;
    localparam int PKT_W    = 48;
    localparam int FLAG_BIT = 24;

    typedef enum logic {EMPTY, HALF} state_t;
endpackage

// File: rtl/tpx3_packet_merger_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and increment enable
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             WCLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clear wins over increment; hold once all ones
    always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    // counter register
    always_ff @(posedge WCLK) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/tpx3_packet_merger.sv
// tpx3_packet_merger: joins 25-bit half-packet words into 48-bit packets; error counters under TPX3_MERGE_ERR_CNT_EN
module tpx3_packet_merger
    import tpx3_rx_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PKT_CNT_W = 16
) (
    input  logic                 WCLK,
    input  logic                 RESET,
    input  logic                 enable,
    input  logic                 err_reset,
    input  logic [WORD_W-1:0]    fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    output logic [PKT_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PKT_CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0]     orphan_cnt,
    output logic [CNT_W-1:0]     dup_first_cnt
);
    state_t               state_q, state_d;
    logic [HALF_W-1:0]    hold_q, hold_d;
    logic [PKT_W-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 orphan_inc, dup_inc, flag;

    assign flag      = fifo_data[FLAG_BIT];
    assign fifo_read = enable & ~RESET & ~fifo_empty & (~out_valid_q | out_ready);

    // pair halves, retire accepted packets, and flag framing errors
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        pkt_cnt_d   = pkt_cnt_q;
        orphan_inc  = 1'b0;
        dup_inc     = 1'b0;
        if (!enable) begin
            state_d = EMPTY;
        end else if (fifo_read) begin
            if (flag) begin
                hold_d  = fifo_data[HALF_W-1:0];
                state_d = HALF;
                dup_inc = (state_q == HALF);
            end else if (state_q == HALF) begin
                out_data_d  = {hold_q, fifo_data[HALF_W-1:0]};
                out_valid_d = 1'b1;
                pkt_cnt_d   = pkt_cnt_q + 1'b1;
                state_d     = EMPTY;
            end else begin
                orphan_inc = 1'b1;
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge WCLK) begin
        if (RESET) begin
            state_q     <= EMPTY;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign pkt_cnt   = pkt_cnt_q;

`ifdef TPX3_MERGE_ERR_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_orphan_cnt (
        .WCLK(WCLK), .RESET(RESET), .clr(err_reset), .inc(orphan_inc), .cnt(orphan_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_dup_first_cnt (
        .WCLK(WCLK), .RESET(RESET), .clr(err_reset), .inc(dup_inc), .cnt(dup_first_cnt)
    );
`else
    logic unused_err;
    assign unused_err    = err_reset ^ orphan_inc ^ dup_inc;
    assign orphan_cnt    = '0;
    assign dup_first_cnt = '0;
`endif
endmodule

// File: tb/tb_tpx3_packet_merger.sv
// tb_tpx3_packet_merger: table-driven check of packet merging, backpressure, enable and error counters
module tb_tpx3_packet_merger;
`ifdef TPX3_MERGE_ERR_CNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic        WCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        enable = 1'b0;
    logic        err_reset = 1'b0;
    logic [24:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] pkt_cnt;
    logic [7:0]  orphan_cnt;
    logic [7:0]  dup_first_cnt;

    int tests = 0;
    int fails = 0;

    tpx3_packet_merger #(.CNT_W(8), .PKT_CNT_W(16)) dut (
        .WCLK(WCLK), .RESET(RESET), .enable(enable), .err_reset(err_reset),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .pkt_cnt(pkt_cnt), .orphan_cnt(orphan_cnt), .dup_first_cnt(dup_first_cnt)
    );

    always #5 WCLK = ~WCLK;

    typedef struct {
        logic [24:0] d;
        logic        empty;
        logic        rdy;
        logic        en;
        logic        exp_rd;
        logic        exp_v;
        logic [47:0] exp_data;
        logic [15:0] exp_pkt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge WCLK);
        #1;
    endtask

    task automatic add(input logic [24:0] d, input logic empty, input logic rdy, input logic en,
                       input logic rd, input logic v, input logic [47:0] data, input logic [15:0] pkt);
        vec_t r;
        r.d = d; r.empty = empty; r.rdy = rdy; r.en = en;
        r.exp_rd = rd; r.exp_v = v; r.exp_data = data; r.exp_pkt = pkt;
        vq.push_back(r);
    endtask

    initial begin
        // basic merge, orphan, duplicate first half, back-to-back throughput
        add(25'h1ABCDEF, 0, 1, 1, 1, 0, 48'h0,            0);
        add(25'h0123456, 0, 1, 1, 1, 1, 48'hABCDEF123456, 1);
        add(25'h0000000, 1, 1, 1, 0, 0, 48'hABCDEF123456, 1);
        add(25'h0000011, 0, 1, 1, 1, 0, 48'hABCDEF123456, 1);
        add(25'h1AAAAAA, 0, 1, 1, 1, 0, 48'hABCDEF123456, 1);
        add(25'h0BBBBBB, 0, 1, 1, 1, 1, 48'hAAAAAABBBBBB, 2);
        add(25'h1111111, 0, 1, 1, 1, 0, 48'hAAAAAABBBBBB, 2);
        add(25'h1222222, 0, 1, 1, 1, 0, 48'hAAAAAABBBBBB, 2);
        add(25'h0333333, 0, 1, 1, 1, 1, 48'h222222333333, 3);
        add(25'h1000001, 0, 1, 1, 1, 0, 48'h222222333333, 3);
        add(25'h0000002, 0, 1, 1, 1, 1, 48'h000001000002, 4);
        add(25'h1000003, 0, 1, 1, 1, 0, 48'h000001000002, 4);
        add(25'h0000004, 0, 1, 1, 1, 1, 48'h000003000004, 5);
        // five cycles of backpressure with data waiting
        for (int i = 0; i < 5; i++)
            add(25'h1000005, 0, 0, 1, 0, 1, 48'h000003000004, 5);
        add(25'h1000005, 0, 1, 1, 1, 0, 48'h000003000004, 5);
        add(25'h0000006, 0, 1, 1, 1, 1, 48'h000005000006, 6);
        // held half survives an empty FIFO
        add(25'h1000007, 0, 1, 1, 1, 0, 48'h000005000006, 6);
        add(25'h0000000, 1, 1, 1, 0, 0, 48'h000005000006, 6);
        add(25'h0000000, 1, 1, 1, 0, 0, 48'h000005000006, 6);
        add(25'h0000008, 0, 1, 1, 1, 1, 48'h000007000008, 7);
        // enable low drops the held half; the next second half is an orphan
        add(25'h1000009, 0, 1, 1, 1, 0, 48'h000007000008, 7);
        add(25'h000000A, 0, 1, 0, 0, 0, 48'h000007000008, 7);
        add(25'h000000A, 0, 1, 1, 1, 0, 48'h000007000008, 7);
        add(25'h100000B, 0, 1, 1, 1, 0, 48'h000007000008, 7);
        add(25'h000000C, 0, 0, 1, 1, 1, 48'h00000B00000C, 8);
        // pending packet unaffected by enable low until accepted
        add(25'h100000D, 0, 0, 0, 0, 1, 48'h00000B00000C, 8);
        add(25'h100000D, 0, 1, 0, 0, 0, 48'h00000B00000C, 8);

        // reset state, with enable high and data present to expose read gating
        enable = 1'b1; fifo_empty = 1'b0; fifo_data = 25'h1ABCDEF;
        step(); step();
        chk("reset_read", fifo_read, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_pkt", pkt_cnt, 0);
        chk("reset_orphan", orphan_cnt, 0);
        chk("reset_dup", dup_first_cnt, 0);
        RESET = 1'b0; enable = 1'b0; fifo_empty = 1'b1;
        step();

        foreach (vq[i]) begin
            fifo_data = vq[i].d; fifo_empty = vq[i].empty;
            out_ready = vq[i].rdy; enable = vq[i].en;
            #1;
            chk($sformatf("row%0d_read", i), fifo_read, vq[i].exp_rd);
            step();
            chk($sformatf("row%0d_valid", i), out_valid, vq[i].exp_v);
            chk($sformatf("row%0d_data", i), out_data, vq[i].exp_data);
            chk($sformatf("row%0d_pkt", i), pkt_cnt, vq[i].exp_pkt);
        end
        chk("tbl_orphan", orphan_cnt, ERR_EN ? 2 : 0);
        chk("tbl_dup", dup_first_cnt, ERR_EN ? 1 : 0);

        // err_reset clears only the error counters
        fifo_empty = 1'b1; enable = 1'b1; err_reset = 1'b1;
        step();
        err_reset = 1'b0;
        chk("errrst_orphan", orphan_cnt, 0);
        chk("errrst_dup", dup_first_cnt, 0);
        chk("errrst_pkt", pkt_cnt, 8);

        // RESET while a first half is held
        fifo_empty = 1'b0; fifo_data = 25'h1555555; out_ready = 1'b1;
        step();
        RESET = 1'b1;
        #1;
        chk("rst_half_read", fifo_read, 0);
        step();
        RESET = 1'b0; fifo_data = 25'h0444444;
        step();
        chk("rst_half_valid", out_valid, 0);
        chk("rst_half_pkt", pkt_cnt, 0);
        chk("rst_half_orphan", orphan_cnt, ERR_EN ? 1 : 0);

        // saturation after 300 orphans, then clear
        fifo_data = 25'h0000001;
        for (int i = 0; i < 299; i++) step();
        chk("sat_orphan", orphan_cnt, ERR_EN ? 8'hFF : 0);
        chk("sat_pkt", pkt_cnt, 0);
        chk("sat_valid", out_valid, 0);
        fifo_empty = 1'b1; err_reset = 1'b1;
        step();
        err_reset = 1'b0;
        chk("sat_clear", orphan_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
